// File: rtl/bcd_display_scan_ctrl_pkg.sv
// Shared types, widths and 7-segment tables for the two-digit BCD scan controller.
package bcd_display_scan_ctrl_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned AN_W    = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TENS  = 3'd1,
        GAP_A = 3'd2,
        UNITS = 3'd3,
        GAP_B = 3'd4
    } scan_state_t;

    // Active-high pattern with every segment dark.
    localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

    // Anodes are always active-low.
    localparam logic [AN_W-1:0] AN_OFF   = 2'b11;
    localparam logic [AN_W-1:0] AN_TENS  = 2'b01;
    localparam logic [AN_W-1:0] AN_UNITS = 2'b10;

    typedef struct packed {
        logic [AN_W-1:0]  an;
        logic [SEG_W-1:0] seg;
        logic             frame_tick;
    } disp_out_t;

    // Active-high {g,f,e,d,c,b,a}; codes above 9 stay dark.
    function automatic logic [SEG_W-1:0] seg_pattern(input logic [DIGIT_W-1:0] digit);
        logic [SEG_W-1:0] p;
        case (digit)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = SEG_OFF;
        endcase
        return p;
    endfunction

    function automatic logic [SEG_W-1:0] seg_polarity(input logic [SEG_W-1:0] pattern,
                                                      input bit active_low);
        return active_low ? ~pattern : pattern;
    endfunction

endpackage

// File: rtl/bcd_display_scan_ctrl_if.sv
// Load handshake plus the shared segment/anode display bus.
interface bcd_display_scan_ctrl_if;
    import bcd_display_scan_ctrl_pkg::*;

    logic [DIGIT_W-1:0] value_in;
    logic               load_valid;
    logic               load_ready;
    logic [SEG_W-1:0]   seg;
    logic [AN_W-1:0]    an;
    logic               frame_tick;

    modport master (
        output value_in, load_valid,
        input  load_ready, seg, an, frame_tick
    );

    modport slave (
        input  value_in, load_valid,
        output load_ready, seg, an, frame_tick
    );

endinterface

// File: rtl/bcd_display_scan_ctrl_seg7_encoder.sv
// Combinational digit to active-high 7-segment pattern.
module bcd_display_scan_ctrl_seg7_encoder
    import bcd_display_scan_ctrl_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [SEG_W-1:0]   pattern_c
);

    always_comb begin
        pattern_c = seg_pattern(digit);
    end

endmodule

// File: rtl/bcd_display_scan_ctrl.sv
// Scans a 0..15 value as tens/units onto a common-segment display, with dead-time
// gaps between digits and new values taken only at frame boundaries.
module bcd_display_scan_ctrl
    import bcd_display_scan_ctrl_pkg::*;
#(
    parameter int unsigned REFRESH_DIV    = 50_000,
    parameter int unsigned GAP_CYCLES     = 16,
    parameter bit          BLANK_LEADING  = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bcd_display_scan_ctrl_if.slave bus
);

    localparam int unsigned CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]   SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [SEG_W-1:0]   SEG_DARK  = seg_polarity(SEG_OFF, SEG_ACTIVE_LOW);
    localparam logic [DIGIT_W-1:0] TEN       = DIGIT_W'(10);

    scan_state_t        state, state_nxt;
    logic [CNT_W-1:0]   slot_cnt, slot_nxt;
    logic [DIGIT_W-1:0] pend, pend_nxt;
    logic               pend_valid, pend_valid_nxt;
    logic [DIGIT_W-1:0] disp_val, disp_nxt;
    logic               load_ready_q;
    disp_out_t          out_q, out_nxt;

    logic               accept;
    logic               commit;
    logic               tens_nxt;
    logic [DIGIT_W-1:0] units_nxt;
    logic [SEG_W-1:0]   tens_pat;
    logic [SEG_W-1:0]   units_pat;

    assign accept = bus.load_valid && load_ready_q;

    // Scan sequencing, slot timing and pending/display value handover.
    always_comb begin
        state_nxt = state;
        slot_nxt  = slot_cnt + CNT_W'(1);
        commit    = 1'b0;
        case (state)
            IDLE: begin
                slot_nxt = '0;
                if (pend_valid) begin
                    commit    = 1'b1;
                    state_nxt = TENS;
                end
            end
            TENS: begin
                if (slot_cnt == SLOT_LAST) begin
                    state_nxt = GAP_A;
                    slot_nxt  = '0;
                end
            end
            GAP_A: begin
                if (slot_cnt == GAP_LAST) begin
                    state_nxt = UNITS;
                    slot_nxt  = '0;
                end
            end
            UNITS: begin
                if (slot_cnt == SLOT_LAST) begin
                    state_nxt = GAP_B;
                    slot_nxt  = '0;
                    commit    = pend_valid;
                end
            end
            GAP_B: begin
                if (slot_cnt == GAP_LAST) begin
                    state_nxt = TENS;
                    slot_nxt  = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                slot_nxt  = '0;
            end
        endcase

        disp_nxt = commit ? pend : disp_val;
        pend_nxt = accept ? bus.value_in : pend;
        if (commit) begin
            pend_valid_nxt = 1'b0;
        end else if (accept) begin
            pend_valid_nxt = 1'b1;
        end else begin
            pend_valid_nxt = pend_valid;
        end
    end

    // Digits of the value that will be on display after this edge.
    assign tens_nxt  = (disp_nxt >= TEN);
    assign units_nxt = disp_nxt - (tens_nxt ? TEN : DIGIT_W'(0));

    bcd_display_scan_ctrl_seg7_encoder u_tens_enc (
        .digit     ({{(DIGIT_W-1){1'b0}}, tens_nxt}),
        .pattern_c (tens_pat)
    );

    bcd_display_scan_ctrl_seg7_encoder u_units_enc (
        .digit     (units_nxt),
        .pattern_c (units_pat)
    );

    // Outputs are decoded from the next state so they change on the entering edge.
    always_comb begin
        out_nxt.an         = AN_OFF;
        out_nxt.seg        = SEG_DARK;
        out_nxt.frame_tick = 1'b0;
        case (state_nxt)
            TENS: begin
                if (!(BLANK_LEADING && !tens_nxt)) begin
                    out_nxt.an  = AN_TENS;
                    out_nxt.seg = seg_polarity(tens_pat, SEG_ACTIVE_LOW);
                end
            end
            UNITS: begin
                out_nxt.an         = AN_UNITS;
                out_nxt.seg        = seg_polarity(units_pat, SEG_ACTIVE_LOW);
                out_nxt.frame_tick = (slot_nxt == SLOT_LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            slot_cnt         <= '0;
            pend             <= '0;
            pend_valid       <= 1'b0;
            disp_val         <= '0;
            load_ready_q     <= 1'b1;
            out_q.an         <= AN_OFF;
            out_q.seg        <= SEG_DARK;
            out_q.frame_tick <= 1'b0;
        end else begin
            state        <= state_nxt;
            slot_cnt     <= slot_nxt;
            pend         <= pend_nxt;
            pend_valid   <= pend_valid_nxt;
            disp_val     <= disp_nxt;
            load_ready_q <= !pend_valid_nxt;
            out_q        <= out_nxt;
        end
    end

    assign bus.load_ready = load_ready_q;
    assign bus.an         = out_q.an;
    assign bus.seg        = out_q.seg;
    assign bus.frame_tick = out_q.frame_tick;

endmodule
